// File: rtl/reg_inc_sequencer_if.sv
// Command and register-bank bus between a host controller and reg_inc_sequencer.
// The host drives the command/abort side; the sequencer drives the strobes,
// the shared data_in value and the status flags.
interface reg_inc_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int SEL_W      = 2
);
    // Command handshake
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [SEL_W-1:0]      cmd_sel;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  abort;

    // Register bank controls (one-hot strobes, shared data_in)
    logic [NUM_REGS-1:0]   reg_we;
    logic [NUM_REGS-1:0]   reg_clr;
    logic [NUM_REGS-1:0]   reg_inc;
    logic [DATA_WIDTH-1:0] reg_data;

    // Status
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_data, abort,
        input  cmd_ready, reg_we, reg_clr, reg_inc, reg_data, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_data, abort,
        output cmd_ready, reg_we, reg_clr, reg_inc, reg_data, busy, done, err
    );
endinterface

// File: rtl/reg_inc_sequencer.sv
// Command-driven sequencer for a bank of incrementable registers.
// Accepts one LOAD / CLEAR / INC / INC_N command at a time and drives at most
// one register strobe per cycle, ending every command with a one-cycle done
// pulse (plus err when the selected register does not exist).
module reg_inc_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int SEL_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    reg_inc_sequencer_if.slave bus
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_INC_N = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            op_q;
    logic [SEL_W-1:0]      sel_q;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;
    logic                  sel_ok;
    logic [NUM_REGS-1:0]   sel_onehot;

    assign sel_ok     = int'(bus.cmd_sel) < NUM_REGS;
    assign sel_onehot = NUM_REGS'(1) << sel_q;

    // Command capture, state sequencing and burst counting.
    // NOTE: registers are written with <= so every flop samples pre-edge values;
    // a blocking = here would let later statements see this cycle's updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= OP_LOAD;
            sel_q  <= '0;
            count  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q  <= bus.cmd_op;
                        sel_q <= bus.cmd_sel;
                        err_q <= !sel_ok;
                        if (bus.cmd_op == OP_LOAD) data_q <= bus.cmd_data;
                        if (!sel_ok) begin
                            state <= S_DONE;
                        end else if (bus.cmd_op != OP_INC_N) begin
                            state <= S_EXEC;
                        end else if (bus.cmd_data == '0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_BURST;
                            count <= bus.cmd_data;
                        end
                    end
                end
                S_EXEC: state <= S_DONE;
                S_BURST: begin
                    if (bus.abort) begin
                        count <= '0;
                        state <= S_DONE;
                    end else begin
                        count <= count - DATA_WIDTH'(1);
                        if (count == DATA_WIDTH'(1)) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobe and status decode from the registered state and captures.
    // abort is the single combinational input here: it masks the burst
    // increment in the very cycle it is sampled, so that cycle adds nothing.
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        bus.reg_we  = '0;
        bus.reg_clr = '0;
        bus.reg_inc = '0;
        case (state)
            S_EXEC: begin
                case (op_q)
                    OP_LOAD:  bus.reg_we  = sel_onehot;
                    OP_CLEAR: bus.reg_clr = sel_onehot;
                    default:  bus.reg_inc = sel_onehot;
                endcase
            end
            S_BURST: if (!bus.abort) bus.reg_inc = sel_onehot;
            default: ;
        endcase
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.err       = (state == S_DONE) && err_q;
    assign bus.reg_data  = data_q;

endmodule

// File: tb/tb_reg_inc_sequencer.sv
// Self-checking bench for reg_inc_sequencer with three registers, so that
// sel = 3 exercises the invalid-select path. A per-command expected-cycle
// queue models the outputs; a small register bank driven by the strobes
// provides literal end-value checks.
module tb_reg_inc_sequencer;

    localparam int DW = 8;
    localparam int NR = 3;
    localparam int SW = 2;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] CLEAR = 2'b01;
    localparam logic [1:0] INC   = 2'b10;
    localparam logic [1:0] INC_N = 2'b11;

    typedef struct packed {
        logic          ready;
        logic          busy;
        logic          done;
        logic          err;
        logic [NR-1:0] we;
        logic [NR-1:0] clr;
        logic [NR-1:0] inc;
    } exp_t;

    localparam exp_t IDLE_REC = '{ready: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b0,
                                  we: '0, clr: '0, inc: '0};

    logic clk;
    logic rst;

    reg_inc_sequencer_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_W(SW)) bus ();

    reg_inc_sequencer #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] model_data  = '0;
    logic          model_ready = 1'b1;
    bit            chk_en      = 1'b0;

    logic [DW-1:0] bank [NR];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // External register bank driven by the sequencer's strobes
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (bus.reg_clr[i])      bank[i] <= '0;
            else if (bus.reg_we[i])  bank[i] <= bus.reg_data;
            else if (bus.reg_inc[i]) bank[i] <= bank[i] + 8'd1;
        end
    end

    // Per-cycle comparison of every output against the expected-cycle queue
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_REC;
            model_ready = e.ready;
            check("cycle",
                  32'({bus.cmd_ready, bus.busy, bus.done, bus.err,
                       bus.reg_we, bus.reg_clr, bus.reg_inc, bus.reg_data}),
                  32'({e, model_data}));
            check("strobe_onehot",
                  32'($countones({bus.reg_we, bus.reg_clr, bus.reg_inc}) > 1), 32'd0);
        end
    end

    // Expected output trace for one accepted command, one record per cycle
    task automatic build(input logic [1:0] op, input logic [SW-1:0] sel,
                         input logic [DW-1:0] data, input int abort_at);
        exp_t base;
        exp_t r;
        logic [NR-1:0] oh;
        int n;
        base = '{ready: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0, we: '0, clr: '0, inc: '0};
        oh   = NR'(1) << sel;
        if (op == LOAD) model_data = data;
        if (int'(sel) >= NR) begin
            r = base; r.done = 1'b1; r.err = 1'b1; exp_q.push_back(r);
            return;
        end
        case (op)
            LOAD:  begin r = base; r.we  = oh; exp_q.push_back(r); end
            CLEAR: begin r = base; r.clr = oh; exp_q.push_back(r); end
            INC:   begin r = base; r.inc = oh; exp_q.push_back(r); end
            default: begin
                n = (abort_at >= 0) ? abort_at : int'(data);
                for (int i = 0; i < n; i++) begin
                    r = base; r.inc = oh; exp_q.push_back(r);
                end
                if (abort_at >= 0) exp_q.push_back(base);
            end
        endcase
        r = base; r.done = 1'b1; exp_q.push_back(r);
    endtask

    // Present a command and hold it until the model says it is accepted.
    // Called and returns at posedge+1. abort_at >= 0 raises abort after that
    // many burst increments.
    task automatic issue(input logic [1:0] op, input logic [SW-1:0] sel,
                         input logic [DW-1:0] data, input int abort_at, input bit keep);
        bit got;
        got = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_sel   = sel;
        bus.cmd_data  = data;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            if (model_ready) begin
                got = 1'b1;
                build(op, sel, data, abort_at);
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        #1;
        if (!keep) bus.cmd_valid = 1'b0;
        if (got && abort_at >= 0) begin
            repeat (abort_at) @(posedge clk);
            #1 bus.abort = 1'b1;
            @(posedge clk);
            #1 bus.abort = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && model_ready) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_data  = '0;
        model_ready = 1'b1;
    endtask

    initial begin
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = LOAD;
        bus.cmd_sel   = '0;
        bus.cmd_data  = '0;
        bus.abort     = 1'b0;

        // Reset asserted mid-cycle: outputs clear immediately
        #3 rst = 1'b1;
        #1;
        check("reset_outputs",
              32'({bus.reg_we, bus.reg_clr, bus.reg_inc, bus.done, bus.err, bus.reg_data}), 32'd0);
        check("reset_ready", 32'({bus.cmd_ready, bus.busy}), 32'b10);
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // LOAD sel=2 0x5A
        issue(LOAD, 2'd2, 8'h5A, -1, 1'b0);
        wait_idle();
        check("bank2_load", 32'(bank[2]), 32'h5A);

        // Preload reg1 = 0x10, then INC_N 3 -> 0x13
        issue(LOAD, 2'd1, 8'h10, -1, 1'b0);
        wait_idle();
        issue(INC_N, 2'd1, 8'd3, -1, 1'b0);
        wait_idle();
        check("bank1_inc3", 32'(bank[1]), 32'h13);

        // INC_N with zero count: done only, register unchanged
        issue(INC_N, 2'd1, 8'd0, -1, 1'b0);
        wait_idle();
        check("bank1_inc0", 32'(bank[1]), 32'h13);

        // INC_N 200 aborted after two increments, then CLEAR
        issue(LOAD, 2'd0, 8'h20, -1, 1'b0);
        wait_idle();
        issue(INC_N, 2'd0, 8'd200, 2, 1'b0);
        wait_idle();
        check("bank0_abort", 32'(bank[0]), 32'h22);
        issue(CLEAR, 2'd0, 8'hFF, -1, 1'b0);
        wait_idle();
        check("bank0_clear", 32'(bank[0]), 32'h00);

        // abort held through a single INC has no effect outside a burst
        bus.abort = 1'b1;
        issue(INC, 2'd0, 8'h00, -1, 1'b0);
        wait_idle();
        bus.abort = 1'b0;
        check("bank0_inc_abort_ignored", 32'(bank[0]), 32'h01);

        // Invalid select with cmd_valid held: err+done, second accept only once idle
        issue(INC_N, 2'd3, 8'd7, -1, 1'b1);
        issue(INC_N, 2'd3, 8'd7, -1, 1'b0);
        wait_idle();
        check("banks_after_err", 32'({bank[0], bank[1], bank[2]}), 32'h01135A);

        // Reset during a 50-increment burst after ten increments
        issue(INC_N, 2'd2, 8'd50, -1, 1'b0);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("reset_burst_outputs",
              32'({bus.reg_inc, bus.done, bus.err, bus.reg_data}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("bank2_partial_burst", 32'(bank[2]), 32'h64);
        issue(INC, 2'd2, 8'h00, -1, 1'b0);
        wait_idle();
        check("bank2_after_reset", 32'(bank[2]), 32'h65);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
